// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared definitions for the booth_mult sequential multiplier:
//                FSM state width and state enumeration.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  // Width of the encoded controller state.
  localparam int STATE_W = 2;

  // IDLE : waiting for mult_start
  // RUN  : Booth steps in progress, followed by one result-write cycle
  // DONE : result just written; mult_end high for this single cycle
  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/booth_mult_if.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mult_if
//  Description : Request/result bundle of the booth_mult multiplier.
//                master : requester (drives start/operands, reads results)
//                slave  : multiplier (reads start/operands, drives results)
//  Signals     : mult_start - request to begin an operation
//                signed_op  - 1 = two's complement operands, 0 = unsigned
//                acc_op     - accumulate into {hi,lo} (BOOTH_MULT_ACC_EN only)
//                A, B       - multiplicand / multiplier
//                busy       - operation in progress
//                mult_end   - one-cycle completion pulse
//                hi, lo     - upper / lower halves of the 2*WIDTH result
//  Options     : BOOTH_MULT_ACC_EN adds the acc_op signal.
//  Revision    : 1.0 - initial release
// ============================================================================
interface booth_mult_if #(
  parameter int WIDTH = 32
);

  logic             mult_start;
  logic             signed_op;
`ifdef BOOTH_MULT_ACC_EN
  logic             acc_op;
`endif
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             mult_end;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
`ifdef BOOTH_MULT_ACC_EN
    output acc_op,
`endif
    output mult_start,
    output signed_op,
    output A,
    output B,
    input  busy,
    input  mult_end,
    input  hi,
    input  lo
  );

  modport slave (
`ifdef BOOTH_MULT_ACC_EN
    input  acc_op,
`endif
    input  mult_start,
    input  signed_op,
    input  A,
    input  B,
    output busy,
    output mult_end,
    output hi,
    output lo
  );

endinterface : booth_mult_if
`default_nettype wire

// File: rtl/booth_mult_step.sv
`default_nettype none
// ============================================================================
//  Module      : booth_step
//  Description : One combinational radix-2 Booth step. The current multiplier
//                bit and the previously examined bit select add, subtract or
//                pass-through of the (already shifted) multiplicand.
//  Ports       : pair      - {current multiplier bit, previous bit}
//                acc_in    - partial product before this step
//                mcand     - multiplicand aligned to this step's weight
//                acc_out   - partial product after this step
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_step #(
  parameter int PW = 66
) (
  input  logic [1:0]    pair,
  input  logic [PW-1:0] acc_in,
  input  logic [PW-1:0] mcand,
  output logic [PW-1:0] acc_out
);

  always_comb begin
    acc_out = acc_in;
    case (pair)
      2'b01:   acc_out = acc_in + mcand;  // end of a run of ones
      2'b10:   acc_out = acc_in - mcand;  // start of a run of ones
      default: acc_out = acc_in;          // 00 / 11: inside a run, no action
    endcase
  end

endmodule : booth_step
`default_nettype wire

// File: rtl/booth_mult.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mult
//  Description : Sequential radix-2 Booth multiplier, one step per clock.
//                WIDTH+1 multiplier bits are processed (B zero- or sign-
//                extended by one bit) so signed and unsigned operands share
//                the same datapath. A is extended to 2*WIDTH+2 bits, which
//                keeps every partial sum exact, including most-negative^2.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous active-low reset
//                bus  - booth_mult_if.slave (start/operands in, results out)
//  Options     : BOOTH_MULT_ACC_EN - enables acc_op: {hi,lo} += product.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  booth_mult_if.slave bus
);

  localparam int                PW       = 2*WIDTH + 2;
  localparam int                CNT_W    = $clog2(WIDTH + 2);
  // Counter value once all WIDTH+1 Booth steps have been applied; the RUN
  // cycle spent at this value writes the result, so the final (optional
  // accumulate) adder is not chained behind the Booth-step adder.
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;

  logic [CNT_W-1:0]   r_cnt;
  logic [PW-1:0]      r_acc;
  logic [PW-1:0]      r_mcand;
  logic [WIDTH:0]     r_mplier;
  logic               r_prev;
  logic [PW-1:0]      w_acc_step;

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_end;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_result;

`ifdef BOOTH_MULT_ACC_EN
  logic               r_acc_op;
`endif

  // --------------------------------------------------------------------------
  // Controller
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.mult_start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // mult_start is deliberately not looked at here.
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.mult_start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Booth datapath
  // --------------------------------------------------------------------------
  booth_step #(
    .PW (PW)
  ) u_step (
    .pair    ({r_mplier[0], r_prev}),
    .acc_in  (r_acc),
    .mcand   (r_mcand),
    .acc_out (w_acc_step)
  );

  assign w_prod = r_acc[2*WIDTH-1:0];

`ifdef BOOTH_MULT_ACC_EN
  // {hi,lo} cannot change during RUN, so its current value is the value
  // held at the accepting edge.
  assign w_result = r_acc_op ? ({r_hi, r_lo} + w_prod) : w_prod;
`else
  assign w_result = w_prod;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prev   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
`ifdef BOOTH_MULT_ACC_EN
      r_acc_op <= 1'b0;
`endif
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{(PW-WIDTH){bus.signed_op & bus.A[WIDTH-1]}}, bus.A};
      r_mplier <= {bus.signed_op & bus.B[WIDTH-1], bus.B};
      r_prev   <= 1'b0;
`ifdef BOOTH_MULT_ACC_EN
      r_acc_op <= bus.acc_op;
`endif
    end else if (r_state == RUN) begin
      if (r_cnt == LAST_CNT) begin
        {r_hi, r_lo} <= w_result;
      end else begin
        r_acc    <= w_acc_step;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_prev   <= r_mplier[0];
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  // Registered status flags, decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_end  <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == RUN);
      r_end  <= (w_state_nxt == DONE);
    end
  end

  // Guard bits above the 2*WIDTH product only absorb intermediate growth.
  logic unused_acc_guard;
  assign unused_acc_guard = ^r_acc[PW-1:2*WIDTH];

  assign bus.busy     = r_busy;
  assign bus.mult_end = r_end;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule : booth_mult
`default_nettype wire

// File: tb/tb_booth_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_mult
//  Description : Self-checking bench for booth_mult (WIDTH=32). A cycle-level
//                reference model predicts busy, mult_end and {hi,lo}; a
//                compare process checks them every cycle, and directed
//                vectors check results and latency against literals.
//  Options     : BOOTH_MULT_ACC_EN - also exercises back-to-back accumulate.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mult;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_mult_if #(.WIDTH(W)) bus ();

  booth_mult #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Exact product, low 64 bits, from plain extended arithmetic.
  function automatic logic [63:0] product(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // ---------------- reference model ----------------
  bit          m_run = 1'b0;
  bit          m_end = 1'b0;
  int          m_edges = 0;
  logic [63:0] m_hilo = '0;
  logic [63:0] m_target = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run  = 1'b0;
      m_end  = 1'b0;
      m_edges = 0;
      m_hilo = '0;
    end else begin
      m_end = 1'b0;
      if (m_run) begin
        m_edges++;
        if (m_edges == W + 2) begin
          m_run  = 1'b0;
          m_end  = 1'b1;
          m_hilo = m_target;
        end
      end else if (bus.mult_start) begin
        m_run    = 1'b1;
        m_edges  = 0;
        m_target = product(bus.A, bus.B, bus.signed_op);
`ifdef BOOTH_MULT_ACC_EN
        if (bus.acc_op) m_target = m_target + m_hilo;
`endif
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #2;
    if (cmp_en) begin
      check("busy", {63'b0, bus.busy}, {63'b0, m_run});
      check("mult_end", {63'b0, bus.mult_end}, {63'b0, m_end});
      check("hilo", {bus.hi, bus.lo}, m_hilo);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic acc, output logic [63:0] res, output int lat);
    @(negedge clk);
    bus.mult_start = 1'b1;
    bus.A          = a;
    bus.B          = b;
    bus.signed_op  = s;
`ifdef BOOTH_MULT_ACC_EN
    bus.acc_op     = acc;
`else
    if (acc) $display("note: accumulate requested without BOOTH_MULT_ACC_EN");
`endif
    @(negedge clk);
    bus.mult_start = 1'b0;
    lat = 0;
    while (!bus.mult_end && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = {bus.hi, bus.lo};
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
  } vec_t;

  logic [63:0] res;
  int          lat;
  int          ends;
  int          first_end;
  vec_t        vecs[4];

  initial begin
    bus.mult_start = 1'b0;
    bus.signed_op  = 1'b0;
    bus.A          = '0;
    bus.B          = '0;
`ifdef BOOTH_MULT_ACC_EN
    bus.acc_op     = 1'b0;
`endif
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_hilo", {bus.hi, bus.lo}, 64'h0);
    check("reset_busy", {63'b0, bus.busy}, 64'h0);
    check("reset_end", {63'b0, bus.mult_end}, 64'h0);
    rst = 1'b1;

    // -3 * 7 signed, with latency
    run_op(32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0, res, lat);
    check("lat_m3x7", 64'(lat), 64'd34);
    check("m3x7", res, 64'hFFFF_FFFF_FFFF_FFEB);

    // most-negative squared, signed and unsigned
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, res, lat);
    check("minneg_s", res, 64'h4000_0000_0000_0000);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, res, lat);
    check("minneg_u", res, 64'h4000_0000_0000_0000);

    // all ones
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, res, lat);
    check("ones_u", res, 64'hFFFF_FFFE_0000_0001);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, res, lat);
    check("ones_s", res, 64'h0000_0000_0000_0001);

    // assorted vectors, checked against the model product
    vecs[0] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0};
    vecs[1] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1};
    vecs[2] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[3] = '{32'h0000_0000, 32'hDEAD_BEEF, 1'b1};
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, res, lat);
      check($sformatf("vec%0d", i), res, product(vecs[i].a, vecs[i].b, vecs[i].s));
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'd34);
    end

    // mult_start pulsed mid-RUN with different operands is ignored
    @(negedge clk);
    bus.mult_start = 1'b1;
    bus.A = 32'd100;
    bus.B = 32'd200;
    bus.signed_op = 1'b0;
    @(negedge clk);
    bus.mult_start = 1'b0;
    ends = 0;
    first_end = 0;
    res = '0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) begin
        bus.mult_start = 1'b1;
        bus.A = 32'd7;
        bus.B = 32'd9;
      end else if (k == 6) begin
        bus.mult_start = 1'b0;
      end
      @(negedge clk);
      if (bus.mult_end) begin
        ends++;
        if (first_end == 0) begin
          first_end = k;
          res = {bus.hi, bus.lo};
        end
      end
    end
    check("midrun_ends", 64'(ends), 64'd1);
    check("midrun_lat", 64'(first_end), 64'd34);
    check("midrun_res", res, 64'd20000);

    // reset at step 10 aborts with no pulse
    @(negedge clk);
    bus.mult_start = 1'b1;
    bus.A = 32'd123;
    bus.B = 32'd456;
    @(negedge clk);
    bus.mult_start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ends = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.mult_end) ends++;
    end
    check("rst_no_end", 64'(ends), 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'h0);
    run_op(32'd5, 32'd6, 1'b0, 1'b0, res, lat);
    check("post_rst_lo", {32'b0, res[31:0]}, 64'd30);
    check("post_rst_hi", {32'b0, res[63:32]}, 64'd0);

`ifdef BOOTH_MULT_ACC_EN
    // 2*3 then, with no idle cycle, accumulate 4*5
    run_op(32'd2, 32'd3, 1'b0, 1'b0, res, lat);
    check("acc_first", res, 64'd6);
    bus.mult_start = 1'b1;
    bus.A = 32'd4;
    bus.B = 32'd5;
    bus.acc_op = 1'b1;
    @(negedge clk);
    bus.mult_start = 1'b0;
    bus.acc_op = 1'b0;
    check("b2b_busy", {63'b0, bus.busy}, 64'd1);
    lat = 0;
    while (!bus.mult_end && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("acc_lat", 64'(lat), 64'd34);
    check("acc_lo", {32'b0, bus.lo}, 64'd26);
    check("acc_hi", {32'b0, bus.hi}, 64'd0);
`endif

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_booth_mult
`default_nettype wire

// File: doc/booth_mult.md
BOOTH_MULT -- requirements
Module: booth_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal 4..64).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port mult_start, input, 1, request to begin an operation.
REQ-005 SHALL have port signed_op, input, 1, operand interpretation: 1 = two's complement, 0 = unsigned.
REQ-006 SHALL have port acc_op, input, 1, accumulate mode (present only with BOOTH_MULT_ACC_EN).
REQ-007 SHALL have ports A and B, input, WIDTH each, multiplicand and multiplier.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 SHALL have port mult_end, output, 1, one-cycle completion pulse.
REQ-010 SHALL have ports hi and lo, output, WIDTH each, upper and lower halves of the 2*WIDTH result.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 SHALL accept mult_start only in IDLE or DONE, latching A, B, signed_op and acc_op on that edge, clearing the step counter, and entering RUN.
REQ-013 SHALL ignore mult_start while in RUN, with no effect on the latched operands or the result.
REQ-014 SHALL, in RUN, perform one radix-2 Booth step per cycle over WIDTH+1 multiplier bits, with B zero-extended when signed_op=0 and sign-extended when signed_op=1.
REQ-015 SHALL extend A to 2*WIDTH+2 bits, by zero or sign per signed_op, before shifting, so no step can overflow, including A=B=most-negative.
REQ-016 SHALL leave RUN after exactly WIDTH+1 step cycles and enter DONE.
REQ-017 SHALL, on entry to DONE, load {hi,lo} with the low 2*WIDTH bits of the product, and assert mult_end for exactly that one cycle.
REQ-018 SHALL move from DONE to IDLE when mult_start is low, or back to RUN when mult_start is high (back-to-back, no bubble).
REQ-019 SHALL hold hi and lo unchanged at all times other than the DONE-entry update.
REQ-020 SHALL drive busy high in RUN only.
REQ-021 SHALL give a latency of WIDTH+2 rising edges from the accepting edge to the edge asserting mult_end.

Reset
REQ-022 SHALL, on rst low and regardless of clock, force state=IDLE, busy=0, mult_end=0, hi=0, lo=0, counter=0 and the internal accumulator to 0.
REQ-023 SHALL abort an operation in RUN on reset with no mult_end pulse, and accept a new mult_start on the first rising edge after rst returns high.

Configuration
REQ-024 SHALL, with BOOTH_MULT_ACC_EN defined, provide acc_op; an operation with acc_op=1 SHALL load {hi,lo} with {hi,lo}+product modulo 2^(2*WIDTH), using the hi/lo values held at the accepting edge.
REQ-025 SHALL, without BOOTH_MULT_ACC_EN, omit the acc_op port and always overwrite {hi,lo} with the product.

Structure
REQ-026 SHALL take the FSM state enum (IDLE/RUN/DONE) and the state-width constant from shared package mult_pkg.
REQ-027 SHALL place the combinational Booth step (bit-pair decode, add/sub/none of the shifted multiplicand) in one sub-module, booth_step, instantiated once.

Verification
REQ-028 SHALL cover, at WIDTH=32, signed_op=1, A=-3, B=7 -> mult_end 34 edges after the accepting edge, {hi,lo}=64'hFFFF_FFFF_FFFF_FFEB.
REQ-029 SHALL cover A=B=32'h8000_0000 -> signed_op=1 gives {hi,lo}=64'h4000_0000_0000_0000; signed_op=0 gives 64'h4000_0000_0000_0000.
REQ-030 SHALL cover signed_op=0, A=B=32'hFFFF_FFFF -> {hi,lo}=64'hFFFF_FFFE_0000_0001; same operands with signed_op=1 -> 64'h0000_0000_0000_0001.
REQ-031 SHALL cover mult_start pulsed mid-RUN with different operands -> ignored, result matches the first operands, single mult_end.
REQ-032 SHALL cover rst low for 1 cycle at step 10 -> no mult_end, hi=lo=0, and a following 5*6 operation -> lo=30.
REQ-033 SHALL cover, with BOOTH_MULT_ACC_EN, 2*3 followed back-to-back by acc_op=1 4*5 -> second mult_end with lo=26, and zero idle cycles between the operations.
